ad2s1210_read_scheduler: RTL

//  Arbitrates angle, speed and fault-register read requests onto the single serial port of the ad2s1210 driver.

---
 rtl/ad2s1210_pkg.sv | 26 ++
 rtl/ad2s1210_read_scheduler_rr_arbiter_3.sv | 26 ++
 rtl/ad2s1210_read_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ad2s1210_pkg.sv
// Shared types for the ad2s1210 read scheduler: request encoding (matches the
// driver dest field) and scheduler FSM states.
package ad2s1210_pkg;

   typedef enum logic [1:0] {
      REQ_ANGLE = 2'd0,
      REQ_SPEED = 2'd1,
      REQ_FAULT = 2'd2
   } req_type_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      GAP
   } sched_state_t;

   function automatic req_type_t next_slot(input req_type_t t);
      case (t)
         REQ_ANGLE: return REQ_SPEED;
         REQ_SPEED: return REQ_FAULT;
         default:   return REQ_ANGLE;
      endcase
   endfunction

endpackage

// File: rtl/ad2s1210_read_scheduler_rr_arbiter_3.sv
// Three-way round-robin arbiter: searches pending slots starting at i_start
// in angle -> speed -> fault order and returns a one-hot grant plus its index.
module rr_arbiter_3
   import ad2s1210_pkg::*;
(
   input  logic [2:0] i_pending,
   input  req_type_t  i_start,
   output logic [2:0] o_grant,
   output req_type_t  o_grant_idx
);

   always_comb begin
      req_type_t w_slot;
      o_grant     = 3'b000;
      o_grant_idx = i_start;
      w_slot      = i_start;
      for (int k = 0; k < 3; k++) begin
         if (o_grant == 3'b000 && i_pending[w_slot]) begin
            o_grant[w_slot] = 1'b1;
            o_grant_idx     = w_slot;
         end
         w_slot = next_slot(w_slot);
      end
   end

endmodule

// File: rtl/ad2s1210_read_scheduler.sv
// Serialises angle/speed/fault read requests onto the single ad2s1210 driver
// port, with a watchdog on each transfer and saturating overrun/timeout counters.
module ad2s1210_read_scheduler
   import ad2s1210_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int GAP_CYCLES     = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_angle_req,
   input  logic                 i_speed_req,
   input  logic                 i_fault_req,
   input  logic                 i_drv_done,
   input  logic                 i_clear_counters,
   output logic                 o_read_angle,
   output logic                 o_read_speed,
   output logic                 o_read_fault,
   output logic                 o_busy,
   output logic [2:0]           o_pending,
   output logic [CNT_WIDTH-1:0] o_overrun_cnt,
   output logic [CNT_WIDTH-1:0] o_timeout_cnt
);

   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam sched_state_t     POST_XFER = (GAP_CYCLES == 0) ? IDLE : GAP;

   sched_state_t         r_state;
   req_type_t            r_ptr;
   logic [2:0]           r_pending;
   logic [2:0]           r_sel;
   logic [2:0]           r_read;
   logic [WD_W-1:0]      r_wdog;
   logic [GAP_W-1:0]     r_gap;
   logic [CNT_WIDTH-1:0] r_ovr_cnt;
   logic [CNT_WIDTH-1:0] r_to_cnt;

   logic [2:0]           w_req;
   logic [2:0]           w_issue_clr;
   logic [2:0]           w_ovr;
   logic [1:0]           w_ovr_n;
   logic [2:0]           w_grant;
   req_type_t            w_grant_idx;
   logic                 w_timeout;
   logic [CNT_WIDTH:0]   w_ovr_sum;
   logic [CNT_WIDTH:0]   w_to_sum;

   rr_arbiter_3 u_arb (
      .i_pending   (r_pending),
      .i_start     (r_ptr),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx)
   );

   assign w_req       = {i_fault_req, i_speed_req, i_angle_req};
   // A request landing on the very cycle its bit is being issued re-arms it
   // rather than counting as an overrun.
   assign w_issue_clr = (r_state == ISSUE) ? r_sel : 3'b000;
   assign w_ovr       = w_req & r_pending & ~w_issue_clr;
   assign w_ovr_n     = {1'b0, w_ovr[0]} + {1'b0, w_ovr[1]} + {1'b0, w_ovr[2]};
   assign w_timeout   = (r_state == WAIT) && !i_drv_done && (r_wdog == WD_LAST);
   assign w_ovr_sum   = {1'b0, r_ovr_cnt} + {{(CNT_WIDTH-1){1'b0}}, w_ovr_n};
   assign w_to_sum    = {1'b0, r_to_cnt} + (CNT_WIDTH+1)'(1);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pending <= 3'b000;
         r_ovr_cnt <= '0;
         r_to_cnt  <= '0;
      end else begin
         r_pending <= (r_pending & ~w_issue_clr) | w_req;
         if (i_clear_counters)
            r_ovr_cnt <= '0;
         else if (w_ovr_n != 2'd0)
            r_ovr_cnt <= w_ovr_sum[CNT_WIDTH] ? '1 : w_ovr_sum[CNT_WIDTH-1:0];
         if (i_clear_counters)
            r_to_cnt <= '0;
         else if (w_timeout)
            r_to_cnt <= w_to_sum[CNT_WIDTH] ? '1 : w_to_sum[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
         r_ptr   <= REQ_ANGLE;
         r_sel   <= 3'b000;
         r_read  <= 3'b000;
         r_wdog  <= '0;
         r_gap   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|r_pending) begin
                  r_state <= ISSUE;
                  r_sel   <= w_grant;
                  r_read  <= w_grant;
                  r_ptr   <= next_slot(w_grant_idx);
               end
            end
            ISSUE: begin
               r_read  <= 3'b000;
               r_wdog  <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               // Done beats a same-cycle watchdog expiry; an aborted read is dropped.
               if (i_drv_done || r_wdog == WD_LAST) begin
                  r_state <= POST_XFER;
                  r_gap   <= '0;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            GAP: begin
               if (r_gap == GAP_LAST) r_state <= IDLE;
               else                   r_gap   <= r_gap + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_read_angle  = r_read[0];
   assign o_read_speed  = r_read[1];
   assign o_read_fault  = r_read[2];
   assign o_busy        = (r_state == ISSUE) || (r_state == WAIT);
   assign o_pending     = r_pending;
   assign o_overrun_cnt = r_ovr_cnt;
   assign o_timeout_cnt = r_to_cnt;

endmodule
